// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one external memory port between I-cache
// refills and D-cache refills/writebacks, one command + fixed burst each.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ic_*              I-cache request/addr in; gnt/rvalid/done out
//   dc_*              D-cache request/we/addr/wdata in; gnt/rvalid/done/wnext out
//   rdata, beat_idx   shared read data and beat index
//   mem_cmd_*         command channel (valid/ready, addr, we)
//   mem_w*            write beat channel; mem_r* read beat channel
//   owner, ic_waiting status for hazard statistics
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_gnt,
    output logic                          ic_rvalid,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic                          dc_wnext,
    output logic                          dc_gnt,
    output logic                          dc_rvalid,
    output logic                          dc_done,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic [ADDR_W-1:0]             mem_cmd_addr,
    output logic                          mem_cmd_we,
    output logic                          mem_wvalid,
    input  logic                          mem_wready,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [1:0]                    owner,
    output logic                          ic_waiting
);

    localparam int BW = $clog2(LINE_WORDS);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    logic [2:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              first_q, first_d;

    logic sel_i, sel_d;
    logic in_cmd, in_rdata, in_wdata, in_done, rd_beat;

    // I wins when alone, or when it has lost STARVE_MAX times in a row.
    assign sel_i = ic_req && (!dc_req || starve_q == STARVE_LIM);
    assign sel_d = !sel_i && dc_req;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        first_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_i) begin
                    owner_d = OWN_I;
                    addr_d  = ic_addr;
                    we_d    = 1'b0;
                    state_d = S_CMD;
                    first_d = 1'b1;
                end else if (sel_d) begin
                    owner_d = OWN_D;
                    addr_d  = dc_addr;
                    we_d    = dc_we;
                    state_d = S_CMD;
                    first_d = 1'b1;
                end
                // sel_d with ic_req high means I lost an arbitration
                if (sel_i || !ic_req) begin
                    starve_d = '0;
                end else if (sel_d && starve_q != STARVE_LIM) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_WDATA : S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_DONE;
                end
            end
            S_WDATA: begin
                if (mem_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_DONE;
                end
            end
            S_DONE: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            starve_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            first_q  <= first_d;
        end
    end

    assign in_cmd   = state_q == S_CMD;
    assign in_rdata = state_q == S_RDATA;
    assign in_wdata = state_q == S_WDATA;
    assign in_done  = state_q == S_DONE;
    assign rd_beat  = in_rdata && mem_rvalid;

    // first_q is set only on the IDLE->CMD transition
    assign ic_gnt = first_q && owner_q == OWN_I;
    assign dc_gnt = first_q && owner_q == OWN_D;

    assign mem_cmd_valid = in_cmd;
    assign mem_cmd_addr  = in_cmd ? addr_q : '0;
    assign mem_cmd_we    = in_cmd && we_q;

    assign ic_rvalid = rd_beat && owner_q == OWN_I;
    assign dc_rvalid = rd_beat && owner_q == OWN_D;
    assign rdata     = rd_beat ? mem_rdata : '0;
    assign beat_idx  = (in_rdata || in_wdata) ? cnt_q : '0;

    assign mem_wvalid = in_wdata;
    assign mem_wdata  = in_wdata ? dc_wdata : '0;
    assign dc_wnext   = in_wdata && mem_wready;

    assign ic_done = in_done && owner_q == OWN_I;
    assign dc_done = in_done && owner_q == OWN_D;

    assign owner      = owner_q;
    assign ic_waiting = ic_req && owner_q != OWN_I && !ic_done;

endmodule
